// File: rtl/video_types_pkg.sv
// Shared video timing types: LCD mode encoding, STAT select layout and
// the dot/line timing constants used by the LCD sequencer.
package video_types;

    localparam logic [8:0] DOTS_PER_LINE = 9'd456;
    localparam logic [8:0] OAM_DOTS      = 9'd80;
    localparam logic [8:0] XFER_DOTS     = 9'd172;
    localparam logic [8:0] HBLANK_START  = OAM_DOTS + XFER_DOTS;
    localparam logic [8:0] LAST_DOT      = DOTS_PER_LINE - 9'd1;
    localparam logic [7:0] LCD_LINES     = 8'd144;
    localparam logic [7:0] VISIBLE_LINES = LCD_LINES;
    localparam logic [7:0] TOTAL_LINES   = 8'd154;
    localparam logic [7:0] LAST_LINE     = TOTAL_LINES - 8'd1;

    typedef enum logic [1:0] {
        HBLANK     = 2'd0,
        VBLANK     = 2'd1,
        OAM_SEARCH = 2'd2,
        TRANSFER   = 2'd3
    } lcd_mode_t;

    // Same bit order as STAT bits 6..3.
    typedef struct packed {
        logic lyc;
        logic mode2;
        logic mode1;
        logic mode0;
    } stat_select_t;

endpackage

// File: rtl/lcd_dot_counter.sv
// Dot/line counter pair. Exposes both the registered position and the
// position it will take on the next edge so the mode logic can register it.
module lcd_dot_counter
    import video_types::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       lcd_enable,
    output logic [8:0] dot,
    output logic [7:0] ly,
    output logic       running,
    output logic [8:0] dot_next,
    output logic [7:0] ly_next,
    output logic       active_next
);

    // The first enabled edge after idle lands on (0,0) instead of advancing.
    always_comb begin
        dot_next    = '0;
        ly_next     = '0;
        active_next = reset & lcd_enable;
        if (active_next && running) begin
            if (dot == LAST_DOT) begin
                dot_next = '0;
                ly_next  = (ly == LAST_LINE) ? 8'd0 : ly + 8'd1;
            end else begin
                dot_next = dot + 9'd1;
                ly_next  = ly;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            dot     <= '0;
            ly      <= '0;
            running <= 1'b0;
        end else begin
            dot     <= dot_next;
            ly      <= ly_next;
            running <= active_next;
        end
    end

endmodule

// File: rtl/lcd_timing_ctrl.sv
// LCD dot/line sequencer: mode FSM, drawline/frame/VBlank strobes and the
// STAT interrupt edge detector. One dot per clk.
module lcd_timing_ctrl
    import video_types::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       lcd_enable,
    input  logic [7:0] lyc,
    input  logic [3:0] stat_sel,
    output logic [7:0] ly,
    output logic [1:0] mode,
    output logic       coincidence,
    output logic       drawline,
    output logic       frame_start,
    output logic       vblank_irq,
    output logic       stat_irq
);

    logic [8:0]   dot;
    logic [8:0]   dot_next;
    logic [7:0]   ly_next;
    logic         running;
    logic         active_next;
    lcd_mode_t    mode_q;
    lcd_mode_t    mode_d;
    logic         drawline_d;
    logic         frame_start_d;
    logic         vblank_d;
    logic         stat_line;
    logic         stat_line_prev;
    stat_select_t sel;

    lcd_dot_counter u_dot_counter (
        .clk         (clk),
        .reset       (reset),
        .lcd_enable  (lcd_enable),
        .dot         (dot),
        .ly          (ly),
        .running     (running),
        .dot_next    (dot_next),
        .ly_next     (ly_next),
        .active_next (active_next)
    );

    // Mode and strobes are decoded from the upcoming position so they line
    // up with the registered dot/ly they describe.
    always_comb begin
        mode_d        = HBLANK;
        drawline_d    = 1'b0;
        frame_start_d = 1'b0;
        vblank_d      = 1'b0;
        if (active_next) begin
            if (ly_next >= VISIBLE_LINES)
                mode_d = VBLANK;
            else if (dot_next < OAM_DOTS)
                mode_d = OAM_SEARCH;
            else if (dot_next < HBLANK_START)
                mode_d = TRANSFER;
            drawline_d    = (ly_next < VISIBLE_LINES) && (dot_next == HBLANK_START);
            frame_start_d = (ly_next == 8'd0) && (dot_next == 9'd0);
            vblank_d      = (ly_next == VISIBLE_LINES) && (dot_next == 9'd0);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            mode_q         <= HBLANK;
            drawline       <= 1'b0;
            frame_start    <= 1'b0;
            vblank_irq     <= 1'b0;
            stat_line_prev <= 1'b0;
        end else begin
            mode_q         <= mode_d;
            drawline       <= drawline_d;
            frame_start    <= frame_start_d;
            vblank_irq     <= vblank_d;
            stat_line_prev <= active_next & stat_line;
        end
    end

    assign mode        = mode_q;
    assign coincidence = (ly == lyc);
    assign sel         = stat_select_t'(stat_sel);

    // Gated by running so the idle/reset HBlank state never raises STAT.
    assign stat_line = running & ((sel.lyc   & coincidence)
                               | (sel.mode2 & (mode_q == OAM_SEARCH))
                               | (sel.mode1 & (mode_q == VBLANK))
                               | (sel.mode0 & (mode_q == HBLANK)));
    assign stat_irq  = stat_line & ~stat_line_prev;

endmodule

// File: tb/tb_lcd_timing_ctrl.sv
// Directed bench for lcd_timing_ctrl: a checkpoint table over one full frame
// plus hand-written disable and reset sequences.
module tb_lcd_timing_ctrl;

    logic       clk;
    logic       reset;
    logic       lcd_enable;
    logic [7:0] lyc;
    logic [3:0] stat_sel;
    logic [7:0] ly;
    logic [1:0] mode;
    logic       coincidence;
    logic       drawline;
    logic       frame_start;
    logic       vblank_irq;
    logic       stat_irq;

    int tests_run = 0;
    int failures  = 0;

    typedef struct {
        int         cyc;
        logic [7:0] ly;
        logic [1:0] mode;
        logic       dl;
        logic       fs;
        logic       vb;
        logic       irq;
        logic       coin;
    } vec_t;

    vec_t vecs[$];

    lcd_timing_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .lcd_enable  (lcd_enable),
        .lyc         (lyc),
        .stat_sel    (stat_sel),
        .ly          (ly),
        .mode        (mode),
        .coincidence (coincidence),
        .drawline    (drawline),
        .frame_start (frame_start),
        .vblank_irq  (vblank_irq),
        .stat_irq    (stat_irq)
    );

    // Clock/reset block.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic add_vec(input int cyc, input int l, input int m, input bit dl,
                           input bit fs, input bit vb, input bit irq, input bit coin);
        vec_t v;
        v.cyc = cyc; v.ly = 8'(l); v.mode = 2'(m);
        v.dl = dl; v.fs = fs; v.vb = vb; v.irq = irq; v.coin = coin;
        vecs.push_back(v);
    endtask

    function automatic bit legal_step(input logic [1:0] from, input logic [1:0] to);
        return (from == to) || (from == 2'd2 && to == 2'd3) || (from == 2'd3 && to == 2'd0)
            || (from == 2'd0 && to == 2'd2) || (from == 2'd0 && to == 2'd1)
            || (from == 2'd1 && to == 2'd2);
    endfunction

    task automatic check_outputs(input string tag, input int l, input int m, input bit dl,
                                 input bit fs, input bit vb, input bit irq);
        check({tag, ".ly"},          32'(ly),          32'(l));
        check({tag, ".mode"},        32'(mode),        32'(m));
        check({tag, ".drawline"},    32'(drawline),    32'(dl));
        check({tag, ".frame_start"}, 32'(frame_start), 32'(fs));
        check({tag, ".vblank_irq"},  32'(vblank_irq),  32'(vb));
        check({tag, ".stat_irq"},    32'(stat_irq),    32'(irq));
    endtask

    initial begin
        int vi        = 0;
        int n_dl      = 0;
        int n_fs      = 0;
        int n_vb      = 0;
        int n_irq     = 0;
        int n_coin    = 0;
        int n_illegal = 0;
        int max_ly    = 0;
        int n_bad     = 0;
        logic [1:0] prev_mode;

        // Frame checkpoints: cycle 0 is the first enabled edge, lyc=10,
        // STAT on LYC until line 12, then on mode 0 / mode 1.
        add_vec(0,      0,   2, 0, 1, 0, 0, 0);
        add_vec(1,      0,   2, 0, 0, 0, 0, 0);
        add_vec(79,     0,   2, 0, 0, 0, 0, 0);
        add_vec(80,     0,   3, 0, 0, 0, 0, 0);
        add_vec(251,    0,   3, 0, 0, 0, 0, 0);
        add_vec(252,    0,   0, 1, 0, 0, 0, 0);
        add_vec(253,    0,   0, 0, 0, 0, 0, 0);
        add_vec(455,    0,   0, 0, 0, 0, 0, 0);
        add_vec(456,    1,   2, 0, 0, 0, 0, 0);
        add_vec(4559,   9,   0, 0, 0, 0, 0, 0);
        add_vec(4560,   10,  2, 0, 0, 0, 1, 1);
        add_vec(4561,   10,  2, 0, 0, 0, 0, 1);
        add_vec(5015,   10,  0, 0, 0, 0, 0, 1);
        add_vec(5016,   11,  2, 0, 0, 0, 0, 0);
        add_vec(5724,   12,  0, 1, 0, 0, 1, 0);
        add_vec(65460,  143, 0, 1, 0, 0, 1, 0);
        add_vec(65663,  143, 0, 0, 0, 0, 0, 0);
        add_vec(65664,  144, 1, 0, 0, 1, 0, 0);
        add_vec(65665,  144, 1, 0, 0, 0, 0, 0);
        add_vec(69768,  153, 1, 0, 0, 0, 0, 0);
        add_vec(70223,  153, 1, 0, 0, 0, 0, 0);
        add_vec(70224,  0,   2, 0, 1, 0, 0, 0);

        // Reset held with lcd_enable low; LYC source selected and matching.
        reset      = 1'b0;
        lcd_enable = 1'b0;
        lyc        = 8'd0;
        stat_sel   = 4'b1000;
        repeat (3) step();
        check_outputs("reset", 0, 0, 0, 0, 0, 0);
        check("reset.coincidence", 32'(coincidence), 32'd1);

        // Full frame against the checkpoint table.
        lyc        = 8'd10;
        reset      = 1'b1;
        lcd_enable = 1'b1;
        prev_mode  = 2'd0;
        for (int k = 0; k <= 70224; k++) begin
            step();
            if (vi < vecs.size() && vecs[vi].cyc == k) begin
                string tag;
                tag = $sformatf("frame@%0d", k);
                check_outputs(tag, int'(vecs[vi].ly), int'(vecs[vi].mode), vecs[vi].dl,
                              vecs[vi].fs, vecs[vi].vb, vecs[vi].irq);
                check({tag, ".coincidence"}, 32'(coincidence), 32'(vecs[vi].coin));
                vi++;
            end
            if (!legal_step(prev_mode, mode)) begin
                n_illegal++;
                $display("FAIL mode_step at %0d: got %0d after %0d", k, mode, prev_mode);
            end
            prev_mode = mode;
            n_dl   += int'(drawline);
            n_fs   += int'(frame_start);
            n_vb   += int'(vblank_irq);
            n_irq  += int'(stat_irq);
            n_coin += int'(coincidence);
            if (int'(ly) > max_ly) max_ly = int'(ly);
            if (k == 5472) stat_sel = 4'b0011;
        end
        check("frame.checkpoints_hit", 32'(vi), 32'(vecs.size()));
        check("frame.drawline_count", 32'(n_dl), 32'd144);
        check("frame.frame_start_count", 32'(n_fs), 32'd2);
        check("frame.vblank_count", 32'(n_vb), 32'd1);
        check("frame.stat_irq_count", 32'(n_irq), 32'd133);
        check("frame.coincidence_cycles", 32'(n_coin), 32'd456);
        check("frame.max_ly", 32'(max_ly), 32'd153);
        check("frame.illegal_transitions", 32'(n_illegal), 32'd0);

        // Disable mid-transfer, hold idle, then re-enable.
        repeat (2380) step();
        check_outputs("pre_disable", 5, 3, 0, 0, 0, 0);
        lcd_enable = 1'b0;
        step();
        check_outputs("disable", 0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 300; k++) begin
            step();
            if (drawline || frame_start || vblank_irq || stat_irq || ly != 8'd0 || mode != 2'd0)
                n_bad++;
        end
        check("disable.idle_activity", 32'(n_bad), 32'd0);
        lcd_enable = 1'b1;
        step();
        check_outputs("reenable", 0, 2, 0, 1, 0, 0);

        // Reset during transfer with lcd_enable still high.
        repeat (3292) step();
        check_outputs("pre_reset", 7, 3, 0, 0, 0, 0);
        reset    = 1'b0;
        lyc      = 8'd0;
        stat_sel = 4'b1000;
        step();
        check_outputs("mid_reset", 0, 0, 0, 0, 0, 0);
        check("mid_reset.coincidence", 32'(coincidence), 32'd1);
        step();
        check("mid_reset.stat_irq_held", 32'(stat_irq), 32'd0);
        stat_sel = 4'b0000;
        reset    = 1'b1;
        step();
        check_outputs("post_reset", 0, 2, 0, 1, 0, 0);
        n_irq = 0;
        n_vb  = 0;
        n_dl  = 0;
        for (int k = 0; k < 500; k++) begin
            step();
            n_irq += int'(stat_irq);
            n_vb  += int'(vblank_irq);
            n_dl  += int'(drawline);
        end
        check("post_reset.stat_irq_count", 32'(n_irq), 32'd0);
        check("post_reset.vblank_count", 32'(n_vb), 32'd0);
        check("post_reset.drawline_count", 32'(n_dl), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests_run, failures);
        $finish;
    end

endmodule
